// File: rtl/scarv_cop_mem_sg.sv
// Scatter/gather and strided CPR load/store engine.
// One element per cop_mem transaction, 8/16/32-bit elements.
module scarv_cop_mem_sg #(
  parameter int CPR_W = 32
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               ivalid,
  input  logic               op_store,
  input  logic               op_indexed,
  input  logic [1:0]         op_ew,
  input  logic [31:0]        gpr_base,
  input  logic [31:0]        gpr_stride,
  input  logic [CPR_W-1:0]   cpr_idx,
  input  logic [CPR_W-1:0]   cpr_data,
  output logic               idone,
  output logic               addr_error,
  output logic               bus_error,
  output logic [CPR_W/8-1:0] rd_ben,
  output logic [CPR_W-1:0]   rd_wdata,
  output logic               cop_mem_cen,
  output logic               cop_mem_wen,
  output logic [31:0]        cop_mem_addr,
  output logic [31:0]        cop_mem_wdata,
  output logic [3:0]         cop_mem_ben,
  input  logic [31:0]        cop_mem_rdata,
  input  logic               cop_mem_stall,
  input  logic               cop_mem_error
);

  localparam int NB = CPR_W / 8;
  localparam int EB = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, CHK, REQ, RSP, DONE, ERR
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [EB-1:0]   e;
  logic [CPR_W-1:0] buffer;
  logic            err_bus;

  logic [7:0]      sh;
  logic [31:0]     emask;
  logic [31:0]     idx_e;
  logic [31:0]     dat_e;
  logic [31:0]     ea;
  logic [31:0]     lane;
  logic [31:0]     wrep;
  logic [3:0]      wben;
  logic            misal;
  logic            last;

  always_comb begin
    sh    = '0;
    emask = '0;
    wrep  = '0;
    wben  = '0;
    misal = 1'b1;
    unique case (op_ew)
      2'd0: begin
        sh    = 8'(e) << 3;
        emask = 32'h0000_00ff;
        wrep  = {4{dat_e[7:0]}};
        wben  = 4'b0001 << ea[1:0];
        misal = 1'b0;
      end
      2'd1: begin
        sh    = 8'(e) << 4;
        emask = 32'h0000_ffff;
        wrep  = {2{dat_e[15:0]}};
        wben  = 4'b0011 << ea[1:0];
        misal = ea[0];
      end
      2'd2: begin
        sh    = 8'(e) << 5;
        emask = 32'hffff_ffff;
        wrep  = dat_e;
        wben  = 4'b1111;
        misal = |ea[1:0];
      end
      default: misal = 1'b1;
    endcase
  end

  assign idx_e = 32'(cpr_idx >> sh) & emask;
  assign dat_e = 32'(cpr_data >> sh) & emask;
  assign ea    = gpr_base + (op_indexed ? idx_e
                                        : 32'(e) * gpr_stride);
  assign lane  = (cop_mem_rdata >> {ea[1:0], 3'b000}) & emask;
  assign last  = e == EB'((NB >> op_ew) - 1);

  // state register plus element counter, load buffer and fault kind
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state   <= IDLE;
      e       <= '0;
      buffer  <= '0;
      err_bus <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE) begin
        e <= '0;
      end else if (state == RSP && ivalid && !cop_mem_error) begin
        if (!last) e <= e + 1'b1;
        if (!op_store) begin
          buffer <= (buffer & ~(CPR_W'(emask) << sh))
                  | (CPR_W'(lane) << sh);
        end
      end
      if (state == CHK) err_bus <= 1'b0;
      if (state == RSP && cop_mem_error) err_bus <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    if (state != IDLE && !ivalid) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (ivalid) nxt = CHK;
        CHK:  nxt = misal ? ERR : REQ;
        REQ:  if (!cop_mem_stall) nxt = RSP;
        RSP: begin
          if (cop_mem_error) nxt = ERR;
          else if (last)     nxt = DONE;
          else               nxt = CHK;
        end
        DONE:    nxt = IDLE;
        ERR:     nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    idone         = 1'b0;
    addr_error    = 1'b0;
    bus_error     = 1'b0;
    rd_ben        = '0;
    rd_wdata      = '0;
    cop_mem_cen   = 1'b0;
    cop_mem_wen   = 1'b0;
    cop_mem_addr  = '0;
    cop_mem_wdata = '0;
    cop_mem_ben   = '0;
    unique case (state)
      REQ: begin
        cop_mem_cen  = 1'b1;
        cop_mem_wen  = op_store;
        cop_mem_addr = {ea[31:2], 2'b00};
        if (op_store) begin
          cop_mem_wdata = wrep;
          cop_mem_ben   = wben;
        end
      end
      DONE: begin
        idone = 1'b1;
        if (!op_store) begin
          rd_ben   = '1;
          rd_wdata = buffer;
        end
      end
      ERR: begin
        idone      = 1'b1;
        addr_error = !err_bus;
        bus_error  = err_bus;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scarv_cop_mem_sg.sv
// Directed bench for scarv_cop_mem_sg at CPR_W=32 and 128.
// Shared word memory model with stall and error injection.
module tb_scarv_cop_mem_sg;

  logic g_clk = 1'b0;
  logic g_resetn;
  always #5 g_clk = ~g_clk;

  logic         ivalid, sel, op_store, op_indexed;
  logic [1:0]   op_ew;
  logic [31:0]  base, stride;
  logic [127:0] idx, data;

  logic         a_idone, a_aerr, a_berr, a_cen, a_wen;
  logic [3:0]   a_rd_ben, a_ben;
  logic [31:0]  a_rd_wdata, a_addr, a_wdata;
  logic         b_idone, b_aerr, b_berr, b_cen, b_wen;
  logic [15:0]  b_rd_ben;
  logic [3:0]   b_ben;
  logic [127:0] b_rd_wdata;
  logic [31:0]  b_addr, b_wdata;

  logic [31:0]  m_rdata;
  logic         m_err, m_stall;
  logic         m_cen, m_wen, m_idone, m_aerr, m_berr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_ben;
  logic [15:0]  m_rd_ben;
  logic [127:0] m_rd_wdata;

  scarv_cop_mem_sg #(.CPR_W(32)) dut32 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .ivalid(ivalid && !sel), .op_store(op_store),
    .op_indexed(op_indexed), .op_ew(op_ew),
    .gpr_base(base), .gpr_stride(stride),
    .cpr_idx(idx[31:0]), .cpr_data(data[31:0]),
    .idone(a_idone), .addr_error(a_aerr),
    .bus_error(a_berr), .rd_ben(a_rd_ben),
    .rd_wdata(a_rd_wdata), .cop_mem_cen(a_cen),
    .cop_mem_wen(a_wen), .cop_mem_addr(a_addr),
    .cop_mem_wdata(a_wdata), .cop_mem_ben(a_ben),
    .cop_mem_rdata(m_rdata), .cop_mem_stall(m_stall),
    .cop_mem_error(m_err)
  );

  scarv_cop_mem_sg #(.CPR_W(128)) dut128 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .ivalid(ivalid && sel), .op_store(op_store),
    .op_indexed(op_indexed), .op_ew(op_ew),
    .gpr_base(base), .gpr_stride(stride),
    .cpr_idx(idx), .cpr_data(data),
    .idone(b_idone), .addr_error(b_aerr),
    .bus_error(b_berr), .rd_ben(b_rd_ben),
    .rd_wdata(b_rd_wdata), .cop_mem_cen(b_cen),
    .cop_mem_wen(b_wen), .cop_mem_addr(b_addr),
    .cop_mem_wdata(b_wdata), .cop_mem_ben(b_ben),
    .cop_mem_rdata(m_rdata), .cop_mem_stall(m_stall),
    .cop_mem_error(m_err)
  );

  assign m_cen      = sel ? b_cen : a_cen;
  assign m_wen      = sel ? b_wen : a_wen;
  assign m_addr     = sel ? b_addr : a_addr;
  assign m_wdata    = sel ? b_wdata : a_wdata;
  assign m_ben      = sel ? b_ben : a_ben;
  assign m_idone    = sel ? b_idone : a_idone;
  assign m_aerr     = sel ? b_aerr : a_aerr;
  assign m_berr     = sel ? b_berr : a_berr;
  assign m_rd_ben   = sel ? b_rd_ben : {12'h0, a_rd_ben};
  assign m_rd_wdata = sel ? b_rd_wdata : {96'h0, a_rd_wdata};

  bit [31:0]   mem [256];
  logic [31:0] acc_addr [64];
  logic [31:0] w_addr [64];
  logic [31:0] w_data [64];
  logic [3:0]  w_ben [64];
  int          acnt = 0, wcount = 0, scnt = 0;
  int          err_abs, stall_abs, stall_lim;
  logic        poke_en;
  logic [31:0] poke_addr, poke_data;

  assign m_stall = m_cen && acnt == stall_abs && scnt < stall_lim;

  always @(posedge g_clk) begin
    m_err   <= 1'b0;
    m_rdata <= '0;
    if (poke_en) mem[poke_addr[9:2]] <= poke_data;
    if (m_stall) scnt <= scnt + 1;
    if (m_cen && !m_stall) begin
      acnt <= acnt + 1;
      acc_addr[acnt % 64] <= m_addr;
      m_rdata <= mem[m_addr[9:2]];
      if (acnt == err_abs) begin
        m_err <= 1'b1;
      end else if (m_wen) begin
        for (int i = 0; i < 4; i++)
          if (m_ben[i])
            mem[m_addr[9:2]][i*8+:8] <= m_wdata[i*8+:8];
        w_addr[wcount % 64] <= m_addr;
        w_data[wcount % 64] <= m_wdata;
        w_ben[wcount % 64]  <= m_ben;
        wcount <= wcount + 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic poke(input logic [31:0] a,
                      input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge g_clk);
    #1 poke_en = 1'b0;
  endtask

  int           cyc;
  logic         r_aerr, r_berr;
  logic [15:0]  r_ben;
  logic [127:0] r_wdata;

  task automatic run(input logic s, input logic st,
                     input logic ix, input logic [1:0] ew,
                     input logic [31:0] b, input logic [31:0] sd,
                     input logic [127:0] ix_v,
                     input logic [127:0] d_v);
    logic        got, snap;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_ben;
    sel = s; op_store = st; op_indexed = ix; op_ew = ew;
    base = b; stride = sd; idx = ix_v; data = d_v;
    ivalid = 1'b1;
    got = 1'b0; snap = 1'b0; cyc = 0;
    s_addr = '0; s_wdata = '0; s_ben = '0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(posedge g_clk);
      #1;
      if (m_idone) begin
        got = 1'b1; cyc = c;
        r_aerr = m_aerr; r_berr = m_berr;
        r_ben = m_rd_ben; r_wdata = m_rd_wdata;
      end else if (m_cen && m_stall) begin
        if (!snap) begin
          snap = 1'b1;
          s_addr = m_addr; s_wdata = m_wdata; s_ben = m_ben;
        end else begin
          chk("stall_addr", m_addr, s_addr);
          chk("stall_wdata", m_wdata, s_wdata);
          chk("stall_ben", m_ben, s_ben);
        end
      end
    end
    if (!got) chk("timeout", 0, 1);
    ivalid = 1'b0;
    @(posedge g_clk);
    #1 chk("idone_pulse", m_idone, 0);
  endtask

  int a0, w0, s0, bad;

  initial begin
    g_resetn = 1'b0; ivalid = 1'b0; sel = 1'b0;
    op_store = 1'b0; op_indexed = 1'b0; op_ew = 2'd0;
    base = '0; stride = '0; idx = '0; data = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    err_abs = 1000000; stall_abs = 1000000; stall_lim = 0;
    r_aerr = 1'b0; r_berr = 1'b0; r_ben = '0; r_wdata = '0;
    repeat (3) @(posedge g_clk);
    #1;
    chk("rst_cen", {a_cen, b_cen}, 0);
    chk("rst_idone", {a_idone, b_idone}, 0);
    chk("rst_rd_ben", {a_rd_ben, b_rd_ben}, 0);
    chk("rst_rd_wdata", a_rd_wdata | b_rd_wdata[31:0], 0);
    g_resetn = 1'b1;

    poke(32'h100, 32'h44332211);
    poke(32'h200, 32'h11112222);
    poke(32'h210, 32'h33334444);
    poke(32'h220, 32'h55556666);
    poke(32'h230, 32'h77778888);

    // byte gather, CPR_W=32
    run(0, 0, 1, 0, 32'h100, 0, 128'h03020100, 0);
    chk("gb_wdata", r_wdata, 128'h44332211);
    chk("gb_ben", r_ben, 16'hf);
    chk("gb_cyc", cyc, 13);
    chk("gb_err", {r_aerr, r_berr}, 0);

    // halfword scatter
    w0 = wcount;
    run(0, 1, 1, 1, 32'h100, 0, 128'h00060000, 128'hbeefcafe);
    chk("sh_nwr", wcount - w0, 2);
    chk("sh_a0", w_addr[w0 % 64], 32'h100);
    chk("sh_b0", w_ben[w0 % 64], 4'b0011);
    chk("sh_d0", w_data[w0 % 64] & 32'h0000ffff, 32'hcafe);
    chk("sh_a1", w_addr[(w0 + 1) % 64], 32'h104);
    chk("sh_b1", w_ben[(w0 + 1) % 64], 4'b1100);
    chk("sh_d1", w_data[(w0 + 1) % 64] & 32'hffff0000,
        32'hbeef0000);
    chk("sh_rd_ben", r_ben, 0);
    chk("sh_mem0", mem[8'h40], 32'h4433cafe);
    chk("sh_mem1", mem[8'h41], 32'hbeef0000);

    // strided word load, CPR_W=128
    a0 = acnt;
    run(1, 0, 0, 2, 32'h200, 32'h10, 0, 0);
    chk("sw_wdata", r_wdata,
        {32'h77778888, 32'h55556666, 32'h33334444, 32'h11112222});
    chk("sw_ben", r_ben, 16'hffff);
    chk("sw_cyc", cyc, 13);
    chk("sw_addr1", acc_addr[(a0 + 1) % 64], 32'h210);
    chk("sw_addr3", acc_addr[(a0 + 3) % 64], 32'h230);

    // misaligned halfword gather
    a0 = acnt;
    run(0, 0, 1, 1, 32'h100, 0, 128'h00030000, 0);
    chk("mis_aerr", {r_aerr, r_berr}, 2'b10);
    chk("mis_ben", r_ben, 0);
    chk("mis_nacc", acnt - a0, 1);
    chk("mis_cyc", cyc, 5);

    // illegal element width
    a0 = acnt;
    run(0, 0, 1, 3, 32'h100, 0, 0, 0);
    chk("ew3_aerr", {r_aerr, r_berr}, 2'b10);
    chk("ew3_nacc", acnt - a0, 0);
    chk("ew3_cyc", cyc, 2);

    // strided store, stall on e=2, bus error on e=3
    a0 = acnt; w0 = wcount; s0 = scnt;
    stall_abs = acnt + 2; stall_lim = scnt + 5;
    err_abs = acnt + 3;
    run(1, 1, 0, 2, 32'h300, 32'h4, 0,
        {32'h0badf00d, 32'hdeadbeef, 32'h89abcdef, 32'h01234567});
    chk("st_berr", {r_aerr, r_berr}, 2'b01);
    chk("st_ben", r_ben, 0);
    chk("st_cyc", cyc, 18);
    chk("st_nstall", scnt - s0, 5);
    chk("st_nwr", wcount - w0, 3);
    chk("st_m0", mem[8'hc0], 32'h01234567);
    chk("st_m2", mem[8'hc2], 32'hdeadbeef);
    chk("st_m3", mem[8'hc3], 0);

    // byte gather with bus error on e=1
    err_abs = acnt + 1; stall_abs = 1000000;
    run(0, 0, 1, 0, 32'h100, 0, 128'h03020100, 0);
    chk("lbe_berr", {r_aerr, r_berr}, 2'b01);
    chk("lbe_ben", r_ben, 0);
    chk("lbe_wdata", r_wdata, 0);
    chk("lbe_cyc", cyc, 7);
    err_abs = 1000000;

    // ivalid dropped in RSP
    sel = 1'b0; op_store = 1'b0; op_indexed = 1'b1;
    op_ew = 2'd0; base = 32'h100; idx = 128'h03020100;
    ivalid = 1'b1;
    repeat (3) @(posedge g_clk);
    #1 ivalid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge g_clk);
      #1 if (m_idone || m_cen) bad++;
    end
    chk("drop_quiet", bad, 0);

    // reset while in REQ
    ivalid = 1'b1;
    repeat (2) @(posedge g_clk);
    #1 chk("rq_cen", m_cen, 1);
    g_resetn = 1'b0; ivalid = 1'b0;
    @(posedge g_clk);
    #1 chk("rq_rst", {m_cen, m_idone}, 0);
    g_resetn = 1'b1;

    run(0, 0, 1, 0, 32'h100, 0, 128'h03020100, 0);
    chk("rec_wdata", r_wdata, 128'h4433cafe);
    chk("rec_cyc", cyc, 13);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
